// File: rtl/decode_stage_pkg.sv
// Shared decode constants: RV32I opcode/funct encodings, the immediate-format enum
// and the encoding legality check used by decode_stage.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_t;

  // True when opcode/funct3/funct7 form a defined RV32I base encoding.
  function automatic logic enc_legal(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [6:0] f7);
    enc_legal = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL: enc_legal = 1'b1;
      OPC_JALR:   enc_legal = (f3 == F3_JALR);
      OPC_BRANCH: enc_legal = (f3 != 3'b010) && (f3 != 3'b011);
      OPC_LOAD:   enc_legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      OPC_STORE:  enc_legal = (f3 <= 3'b010);
      OPC_OPIMM: begin
        if (f3 == F3_SLL)     enc_legal = (f7 == F7_BASE);
        else if (f3 == F3_SR) enc_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else                  enc_legal = 1'b1;
      end
      OPC_OP: enc_legal = (f7 == F7_BASE) ||
                          ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
      default: enc_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// RV32I immediate extraction for a given format, sign-extended to XLEN.
module imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  input  imm_fmt_t        i_fmt,
  output logic [XLEN-1:0] o_imm
);

  logic signed [31:0] w_imm32;
  logic               w_unused_opcode;

  assign w_unused_opcode = ^i_inst[6:0];

  always_comb begin
    w_imm32 = '0;
    case (i_fmt)
      FMT_I: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      FMT_S: w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B: w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                        i_inst[11:8], 1'b0};
      FMT_U: w_imm32 = {i_inst[31:12], 12'b0};
      FMT_J: w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                        i_inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Signed source, so the size cast sign-extends.
  assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field/immediate decode, operand bypass, load-use stall, registered output.
// Optional ID_ILLEGAL_TRAP_EN adds the out_illegal flag for undefined encodings.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         rs1_data,
  input  logic [XLEN-1:0]         rs2_data,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [5*NUM_FWD-1:0]    fwd_addr,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_op1,
  output logic [XLEN-1:0]         out_op2,
  output logic [XLEN-1:0]         out_imm,
  output logic [XLEN-1:0]         out_link,
  output logic [6:0]              out_opcode,
  output logic [2:0]              out_funct3,
  output logic [6:0]              out_funct7,
  output logic [4:0]              out_rd,
  output logic                    out_wreg,
  output logic                    out_is_load,
  output logic                    out_is_store,
`ifdef ID_ILLEGAL_TRAP_EN
  output logic                    out_illegal,
`endif
  output logic                    out_is_branch
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  imm_fmt_t        w_fmt;
  logic            w_writes, w_use_rs1, w_use_rs2, w_legal;
  logic [XLEN-1:0] w_imm, w_rs1_val, w_rs2_val, w_op1, w_op2, w_link;
  logic [NUM_FWD-1:0] w_hit1, w_hit2;
  logic            w_hazard, w_capture;

  logic            r_valid, r_wreg, r_is_load, r_is_store, r_is_branch;
  logic [XLEN-1:0] r_pc, r_op1, r_op2, r_imm, r_link;
  logic [6:0]      r_opcode, r_funct7;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic            r_lp_valid;
  logic [4:0]      r_lp_rd;
`ifdef ID_ILLEGAL_TRAP_EN
  logic            r_illegal;
`endif

  assign w_opcode = in_inst[6:0];
  assign w_rd     = in_inst[11:7];
  assign w_funct3 = in_inst[14:12];
  assign w_rs1    = in_inst[19:15];
  assign w_rs2    = in_inst[24:20];
  assign w_funct7 = in_inst[31:25];
  assign rs1_addr = w_rs1;
  assign rs2_addr = w_rs2;
  assign w_legal  = enc_legal(w_opcode, w_funct3, w_funct7);

  always_comb begin
    w_fmt     = FMT_R;
    w_writes  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin w_fmt = FMT_U; w_writes = 1'b1; end
      OPC_JAL:    begin w_fmt = FMT_J; w_writes = 1'b1; end
      OPC_JALR:   begin w_fmt = FMT_I; w_writes = 1'b1; w_use_rs1 = 1'b1; end
      OPC_BRANCH: begin w_fmt = FMT_B; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_LOAD:   begin w_fmt = FMT_I; w_writes = 1'b1; w_use_rs1 = 1'b1; end
      OPC_STORE:  begin w_fmt = FMT_S; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_OPIMM:  begin w_fmt = FMT_I; w_writes = 1'b1; w_use_rs1 = 1'b1; end
      OPC_OP:     begin w_fmt = FMT_R; w_writes = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      default:    w_fmt = FMT_R;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_inst (in_inst),
    .i_fmt  (w_fmt),
    .o_imm  (w_imm)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FWD; gi++) begin : g_fwd_hit
      assign w_hit1[gi] = fwd_valid[gi] && (fwd_addr[gi*5 +: 5] == w_rs1);
      assign w_hit2[gi] = fwd_valid[gi] && (fwd_addr[gi*5 +: 5] == w_rs2);
    end
  endgenerate

  // Scan from the oldest source down so the youngest matching entry wins.
  always_comb begin
    w_rs1_val = rs1_data;
    w_rs2_val = rs2_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (w_hit1[i]) w_rs1_val = fwd_data[i*XLEN +: XLEN];
      if (w_hit2[i]) w_rs2_val = fwd_data[i*XLEN +: XLEN];
    end
    if (w_rs1 == 5'd0) w_rs1_val = '0;
    if (w_rs2 == 5'd0) w_rs2_val = '0;
  end

  always_comb begin
    w_op1 = w_rs1_val;
    if (w_opcode == OPC_LUI)                              w_op1 = '0;
    else if ((w_opcode == OPC_AUIPC) || (w_opcode == OPC_JAL)) w_op1 = in_pc;
    w_op2  = w_use_rs2 ? w_rs2_val : w_imm;
    w_link = ((w_opcode == OPC_JAL) || (w_opcode == OPC_JALR)) ? in_pc + PC_STEP : '0;
  end

  assign w_hazard  = r_lp_valid && ((w_use_rs1 && (w_rs1 == r_lp_rd)) ||
                                    (w_use_rs2 && (w_rs2 == r_lp_rd)));
  assign in_ready  = !flush && !w_hazard && (!r_valid || out_ready);
  assign w_capture = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_imm       <= '0;
      r_link      <= '0;
      r_opcode    <= '0;
      r_funct3    <= '0;
      r_funct7    <= '0;
      r_rd        <= '0;
      r_wreg      <= 1'b0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_is_branch <= 1'b0;
      r_lp_valid  <= 1'b0;
      r_lp_rd     <= '0;
`ifdef ID_ILLEGAL_TRAP_EN
      r_illegal   <= 1'b0;
`endif
    end else begin
      r_lp_valid <= r_valid && out_ready && r_is_load && (r_rd != 5'd0) && !flush;
      r_lp_rd    <= r_rd;
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid     <= 1'b1;
        r_pc        <= in_pc;
        r_op1       <= w_op1;
        r_op2       <= w_op2;
        r_imm       <= w_imm;
        r_link      <= w_link;
        r_opcode    <= w_opcode;
        r_funct3    <= w_funct3;
        r_funct7    <= w_funct7;
        r_rd        <= w_rd;
        r_wreg      <= w_legal && w_writes && (w_rd != 5'd0);
        r_is_load   <= w_legal && (w_opcode == OPC_LOAD);
        r_is_store  <= w_legal && (w_opcode == OPC_STORE);
        r_is_branch <= w_legal && (w_opcode == OPC_BRANCH);
`ifdef ID_ILLEGAL_TRAP_EN
        r_illegal   <= !w_legal;
`endif
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_valid;
  assign out_pc        = r_pc;
  assign out_op1       = r_op1;
  assign out_op2       = r_op2;
  assign out_imm       = r_imm;
  assign out_link      = r_link;
  assign out_opcode    = r_opcode;
  assign out_funct3    = r_funct3;
  assign out_funct7    = r_funct7;
  assign out_rd        = r_rd;
  assign out_wreg      = r_wreg;
  assign out_is_load   = r_is_load;
  assign out_is_store  = r_is_store;
  assign out_is_branch = r_is_branch;
`ifdef ID_ILLEGAL_TRAP_EN
  assign out_illegal   = r_illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage with a transaction-level reference model
// and directed cases for bypass priority, load-use stall, backpressure, flush and reset.
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam int NF   = 2;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23;
  localparam logic [6:0] OPIMM = 7'h13, OP = 7'h33;

  logic              clk = 1'b0;
  logic              rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [XLEN-1:0]   in_pc, rs1_data, rs2_data;
  logic [31:0]       in_inst;
  logic [4:0]        rs1_addr, rs2_addr;
  logic [NF-1:0]     fwd_valid;
  logic [5*NF-1:0]   fwd_addr;
  logic [XLEN*NF-1:0] fwd_data;
  logic [XLEN-1:0]   out_pc, out_op1, out_op2, out_imm, out_link;
  logic [6:0]        out_opcode, out_funct7;
  logic [2:0]        out_funct3;
  logic [4:0]        out_rd;
  logic              out_wreg, out_is_load, out_is_store, out_is_branch;
`ifdef ID_ILLEGAL_TRAP_EN
  logic              out_illegal;
`endif

  always #5 clk = ~clk;

  logic [31:0] regs [32];
  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];

  decode_stage #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm), .out_link(out_link),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_wreg(out_wreg), .out_is_load(out_is_load),
    .out_is_store(out_is_store),
`ifdef ID_ILLEGAL_TRAP_EN
    .out_illegal(out_illegal),
`endif
    .out_is_branch(out_is_branch)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, op1, op2, imm, link;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        wreg, ld, st, br, ill;
  } txn_t;

  txn_t       mdl;
  logic       lp_v;
  logic [4:0] lp_rd;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic legal(input logic [31:0] inst);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = inst[14:12];
    f7 = inst[31:25];
    case (inst[6:0])
      LUI, AUIPC, JAL: return 1'b1;
      JALR:   return f3 == 3'd0;
      BRANCH: return f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      LOAD:   return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      STORE:  return f3 inside {3'd0, 3'd1, 3'd2};
      OPIMM:  return (f3 == 3'd1) ? (f7 == 7'h00) :
                     (f3 == 3'd5) ? (f7 inside {7'h00, 7'h20}) : 1'b1;
      OP:     return (f7 == 7'h00) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] immv(input logic [31:0] inst);
    logic [31:0] sx;
    sx = inst[31] ? 32'hFFFF_FFFF : 32'h0;
    case (inst[6:0])
      LUI, AUIPC:        return inst & 32'hFFFF_F000;
      JAL:               return (sx << 20) | (32'(inst[19:12]) << 12) |
                                (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
      JALR, LOAD, OPIMM: return (sx << 11) | 32'(inst[30:20]);
      STORE:             return (sx << 11) | (32'(inst[30:25]) << 5) | 32'(inst[11:7]);
      BRANCH:            return (sx << 12) | (32'(inst[7]) << 11) |
                                (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
      default:           return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] src(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    for (int i = 0; i < NF; i++)
      if (fwd_valid[i] && fwd_addr[i*5 +: 5] == a) return fwd_data[i*32 +: 32];
    return regs[a];
  endfunction

  function automatic logic uses1(input logic [31:0] inst);
    return inst[6:0] inside {JALR, BRANCH, LOAD, STORE, OPIMM, OP};
  endfunction

  function automatic logic uses2(input logic [31:0] inst);
    return inst[6:0] inside {BRANCH, STORE, OP};
  endfunction

  function automatic txn_t decode(input logic [31:0] inst, input logic [31:0] pc);
    txn_t t;
    logic ok;
    logic [6:0] opc;
    t   = '0;
    opc = inst[6:0];
    ok  = legal(inst);
    t.valid = 1'b1;
    t.pc    = pc;
    t.opc   = opc;
    t.f3    = inst[14:12];
    t.f7    = inst[31:25];
    t.rd    = inst[11:7];
    t.imm   = immv(inst);
    t.link  = (opc == JAL || opc == JALR) ? pc + 32'd4 : 32'h0;
    t.op1   = (opc == LUI) ? 32'h0 : (opc == AUIPC || opc == JAL) ? pc : src(inst[19:15]);
    t.op2   = (opc inside {OP, BRANCH, STORE}) ? src(inst[24:20]) : t.imm;
    t.wreg  = ok && (opc inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP}) && t.rd != 5'd0;
    t.ld    = ok && opc == LOAD;
    t.st    = ok && opc == STORE;
    t.br    = ok && opc == BRANCH;
    t.ill   = !ok;
    return t;
  endfunction

  function automatic logic model_ready();
    logic hz;
    hz = lp_v && ((uses1(in_inst) && in_inst[19:15] == lp_rd) ||
                  (uses2(in_inst) && in_inst[24:20] == lp_rd));
    return !flush && !hz && (!mdl.valid || out_ready);
  endfunction

  // Compare the DUT against the model, away from the active edge.
  task automatic sample();
    @(negedge clk);
    chk("out_valid", out_valid, mdl.valid);
    chk("in_ready", in_ready, model_ready());
    chk("rs1_addr", rs1_addr, in_inst[19:15]);
    chk("rs2_addr", rs2_addr, in_inst[24:20]);
    if (mdl.valid) begin
      chk("out_pc", out_pc, mdl.pc);
      chk("out_op1", out_op1, mdl.op1);
      chk("out_op2", out_op2, mdl.op2);
      chk("out_imm", out_imm, mdl.imm);
      chk("out_link", out_link, mdl.link);
      chk("out_opcode", out_opcode, mdl.opc);
      chk("out_funct3", out_funct3, mdl.f3);
      chk("out_funct7", out_funct7, mdl.f7);
      chk("out_rd", out_rd, mdl.rd);
      chk("out_wreg", out_wreg, mdl.wreg);
      chk("out_is_load", out_is_load, mdl.ld);
      chk("out_is_store", out_is_store, mdl.st);
      chk("out_is_branch", out_is_branch, mdl.br);
`ifdef ID_ILLEGAL_TRAP_EN
      chk("out_illegal", out_illegal, mdl.ill);
`endif
    end
  endtask

  // Advance the model across the coming edge, then let the edge happen.
  task automatic advance();
    txn_t old;
    logic rdy;
    old = mdl;
    rdy = model_ready();
    if (rst) begin
      mdl   = '0;
      lp_v  = 1'b0;
      lp_rd = 5'd0;
    end else begin
      if (old.valid && out_ready)
        $display("issue pc=%h opc=%h rd=%0d op1=%h op2=%h imm=%h", old.pc, old.opc,
                 old.rd, old.op1, old.op2, old.imm);
      lp_v  = old.valid && out_ready && old.ld && old.rd != 5'd0 && !flush;
      lp_rd = old.rd;
      if (flush)                  mdl.valid = 1'b0;
      else if (in_valid && rdy)   mdl = decode(in_inst, in_pc);
      else if (out_ready)         mdl.valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = LUI;
      1: w[6:0] = AUIPC;
      2: w[6:0] = JAL;
      3: w[6:0] = JALR;
      4: w[6:0] = BRANCH;
      5: w[6:0] = LOAD;
      6: w[6:0] = STORE;
      7, 8: w[6:0] = OPIMM;
      9: w[6:0] = OP;
      default: ;
    endcase
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  initial begin
    mdl       = '0;
    lp_v      = 1'b0;
    lp_rd     = 5'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_inst   = 32'h0;
    in_pc     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;
    fwd_valid = '0;
    fwd_addr  = '0;
    fwd_data  = '0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    sample();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_op1", out_op1, 32'h0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_wreg", out_wreg, 1'b0);
    advance();
    rst = 1'b0;

    // addi x1,x0,5 at 0x100
    present(32'h0050_0093, 32'h100);
    sample(); advance();
    in_valid = 1'b0;
    sample();
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_op1", out_op1, 32'h0);
    chk("addi_imm", out_imm, 32'h5);
    chk("addi_op2", out_op2, 32'h5);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi_wreg", out_wreg, 1'b1);
    advance();

    // add x2,x1,x1 with both bypass sources matching: youngest wins
    regs[1]   = 32'hCC;
    fwd_valid = 2'b11;
    fwd_addr  = {5'd1, 5'd1};
    fwd_data  = {32'hBB, 32'hAA};
    present(32'h0010_8133, 32'h104);
    sample(); advance();
    in_valid  = 1'b0;
    fwd_valid = 2'b00;
    sample();
    chk("fwd_op1", out_op1, 32'hAA);
    chk("fwd_op2", out_op2, 32'hAA);
    advance();

    // lw x3,0(x0) drained, then dependent add x4,x3,x0 stalls one cycle
    present(32'h0000_2183, 32'h108);
    sample(); advance();
    in_valid = 1'b0;
    sample(); advance();
    present(32'h0001_8233, 32'h10C);
    sample();
    chk("loaduse_stall", in_ready, 1'b0);
    advance();
    sample();
    chk("loaduse_release", in_ready, 1'b1);
    advance();
    in_valid = 1'b0;
    sample();
    chk("loaduse_valid", out_valid, 1'b1);
    chk("loaduse_rd", out_rd, 5'd4);
    advance();

    // Backpressure for three cycles, then back-to-back replacement
    present(32'h0050_0093, 32'h200);
    sample(); advance();
    present(32'h0010_8133, 32'h204);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_pc", out_pc, 32'h200);
      chk("bp_hold_imm", out_imm, 32'h5);
      advance();
    end
    out_ready = 1'b1;
    sample();
    chk("bp_release_ready", in_ready, 1'b1);
    advance();
    in_valid = 1'b0;
    sample();
    chk("bp_next_valid", out_valid, 1'b1);
    chk("bp_next_pc", out_pc, 32'h204);
    advance();

    // Flush drops both the held and the incoming instruction
    present(32'h0050_0093, 32'h300);
    sample(); advance();
    present(32'h0010_8133, 32'h304);
    flush     = 1'b1;
    out_ready = 1'b0;
    sample();
    chk("flush_in_ready", in_ready, 1'b0);
    advance();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("flush_out_valid", out_valid, 1'b0);
      advance();
    end

    // All-ones word is an undefined encoding
    present(32'hFFFF_FFFF, 32'h400);
    sample(); advance();
    in_valid = 1'b0;
    sample();
    chk("ill_wreg", out_wreg, 1'b0);
    chk("ill_load", out_is_load, 1'b0);
    chk("ill_store", out_is_store, 1'b0);
    chk("ill_branch", out_is_branch, 1'b0);
`ifdef ID_ILLEGAL_TRAP_EN
    chk("ill_flag", out_illegal, 1'b1);
`endif
    advance();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      in_valid  = ($urandom_range(0, 9) < 8);
      in_inst   = rand_inst();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      fwd_valid = NF'($urandom);
      for (int i = 0; i < NF; i++) fwd_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
      fwd_data  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 31)] = $urandom;
      sample();
      advance();
    end

    // Reset while an instruction is held
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    present(32'h0050_0093, 32'h500);
    sample(); advance();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    sample(); advance();
    rst = 1'b0;
    sample();
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_pc", out_pc, 32'h0);
    chk("midrst_op2", out_op2, 32'h0);
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32; datapath width.
REQ-002 SHALL have parameter NUM_FWD, default 2; number of forwarding sources; index 0 is youngest and has highest priority.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid/in_ready  input/output  1/1  fetch handshake.
REQ-006 SHALL have ports in_pc/in_inst  input  XLEN/32  fetched PC and instruction.
REQ-007 SHALL have ports rs1_addr/rs2_addr  output  5/5  regfile read addresses, combinational from in_inst[19:15]/[24:20].
REQ-008 SHALL have ports rs1_data/rs2_data  input  XLEN/XLEN  regfile read data, same cycle.
REQ-009 SHALL have ports fwd_valid/fwd_addr/fwd_data  input  NUM_FWD/5*NUM_FWD/XLEN*NUM_FWD  bypass sources.
REQ-010 SHALL have port flush  input  1  discard the held and the incoming instruction.
REQ-011 SHALL have ports out_valid/out_ready  output/input  1/1  execute-side handshake.
REQ-012 SHALL have outputs out_pc, out_op1, out_op2, out_imm, out_link, each XLEN wide; out_opcode 7, out_funct3 3, out_funct7 7, out_rd 5; and the flags out_wreg, out_is_load, out_is_store, out_is_branch, 1 bit each.

Function
REQ-013 SHALL register all out_* fields; an instruction accepted at edge N SHALL present out_valid=1 after edge N (1-cycle latency).
REQ-014 SHALL hold all out_* fields stable while out_valid=1 and out_ready=0.
REQ-015 SHALL drive in_ready = !hazard && (!out_valid || out_ready).
REQ-016 SHALL accept an instruction when in_valid && in_ready.
REQ-017 SHALL decode immediates per RV32I I/S/B/U/J formats with sign extension to XLEN; out_imm=0 for R-type.
REQ-018 SHALL set out_link=in_pc+4 for JAL/JALR; otherwise 0.
REQ-019 SHALL set out_op1 to the resolved rs1 value, or in_pc for AUIPC/JAL, or 0 for LUI.
REQ-020 SHALL set out_op2 to the resolved rs2 value for OP/BRANCH/STORE, and to out_imm otherwise.
REQ-021 SHALL resolve each source as follows: address 0 gives 0; otherwise the lowest-index fwd entry with fwd_valid=1 and a matching fwd_addr; otherwise the regfile data.
REQ-022 SHALL set out_wreg=1 only for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP with rd!=0.
REQ-023 SHALL maintain a one-entry load-pending register, loaded with {1,rd} when a LOAD with rd!=0 leaves via out_valid&&out_ready, and cleared on any other edge.
REQ-024 SHALL assert hazard when the load-pending entry is valid and its rd equals a used rs1/rs2 of in_inst; this inserts exactly one bubble.
REQ-025 SHALL, on flush, clear out_valid and the load-pending entry at the next edge; flush SHALL take priority over capture and in_ready SHALL be 0 while flush=1.
REQ-026 SHALL, when capture and drain occur in the same cycle, replace the output register with the new instruction without a bubble.

Reset
REQ-027 SHALL, with rst=1 at an edge, clear out_valid, the load-pending entry, all out_* fields and out_illegal (when present) to 0.
REQ-028 SHALL, when rst is asserted mid-operation, drop any held instruction with no output handshake.

Configuration
REQ-029 SHALL, with ID_ILLEGAL_TRAP_EN defined, provide an out_illegal output (1 bit) that is set for unknown opcode/funct3/funct7, and force out_wreg=0 for such instructions.
REQ-030 SHALL, without ID_ILLEGAL_TRAP_EN, omit out_illegal, pass unknown encodings through with all flags 0, and produce no simulation messages.

Structure
REQ-031 SHALL take opcode, funct3 and funct7 constants and the immediate-format enum from the shared package/defines file.
REQ-032 SHALL place immediate generation in a sub-module imm_gen (inst in, format in, XLEN imm out); operand resolution SHALL stay inline.

Verification
REQ-033 SHALL cover this case: 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle out_valid=1, out_op1=0, out_imm=out_op2=5, out_rd=1, out_wreg=1.
REQ-034 SHALL cover this case: fwd0={1,x1,0xAA}, fwd1={1,x1,0xBB}, regfile 0xCC, add x2,x1,x1 -> out_op1=out_op2=0xAA.
REQ-035 SHALL cover this case: lw x3,0(x0) drained, then add x4,x3,x0 presented -> in_ready=0 for exactly 1 cycle, then accepted.
REQ-036 SHALL cover this case: out_ready=0 for 3 cycles with in_valid=1 -> out_* unchanged and in_ready=0; on release, the next instruction follows back-to-back.
REQ-037 SHALL cover this case: flush=1 with in_valid=1 and out_valid=1 -> out_valid=0 next cycle and both instructions are never issued.
REQ-038 SHALL cover this case: 0xFFFFFFFF -> out_illegal=1 and out_wreg=0 with ID_ILLEGAL_TRAP_EN; out_wreg=0 and all flags 0 without it.
